// File: rtl/systolic_fp_pe.sv
`default_nettype none
// ============================================================================
// Module   : systolic_fp_pe
// Purpose  : Output-stationary systolic floating-point cell. It forwards its
//            operands to the neighbouring cells and accumulates a*b through a
//            two-stage multiply/add pipeline. The sum is drained on request.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_fp_pe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [EXP_W+MAN_W:0]   a_in,
    input  logic [EXP_W+MAN_W:0]   b_in,
    input  logic                   drain,
    output logic [EXP_W+MAN_W:0]   a_out,
    output logic [EXP_W+MAN_W:0]   b_out,
    output logic                   out_valid,
    output logic [EXP_W+MAN_W:0]   acc_out,
    output logic                   acc_valid
);

    localparam int c_w   = 1 + EXP_W + MAN_W;
    localparam int c_pw  = 2 * (MAN_W + 1);
    localparam int c_lzw = $clog2(MAN_W + 2);
    localparam int c_xw  = EXP_W + c_lzw + 2;
    localparam logic [EXP_W-1:0] c_exp_ones = {EXP_W{1'b1}};
    localparam logic [EXP_W+1:0] c_bias     = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
    localparam logic [c_w-1:0]   c_nan      = {1'b0, c_exp_ones, 1'b1, {(MAN_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [c_w-1:0] r_a_out;
    logic [c_w-1:0] r_b_out;
    logic           r_out_valid;
    logic           r_p_valid;
    logic           r_p_drain;
    logic [c_w-1:0] r_prod;
    logic [c_w-1:0] r_acc;
    logic [c_w-1:0] r_acc_out;
    logic           r_acc_valid;

    // ------------------------------------------------------------------
    // Stage 1: multiplier
    // ------------------------------------------------------------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic [c_pw-1:0]  w_prod_man;
    logic [EXP_W+1:0] w_mexp;
    logic [MAN_W-1:0] w_mman;
    logic [c_w-1:0]   w_mul;

    assign {w_sa, w_ea, w_ma} = a_in;
    assign {w_sb, w_eb, w_mb} = b_in;
    assign w_prod_man = {1'b1, w_ma} * {1'b1, w_mb};

    always_comb begin
        w_mul  = '0;
        w_mexp = {2'b00, w_ea} + {2'b00, w_eb} - c_bias
               + {{(EXP_W+1){1'b0}}, w_prod_man[c_pw-1]};
        w_mman = w_prod_man[c_pw-1] ? w_prod_man[c_pw-2 -: MAN_W]
                                    : w_prod_man[c_pw-3 -: MAN_W];
        if (&w_ea || &w_eb) begin
            // inf times zero has no meaningful sign or magnitude
            if (w_ea == '0 || w_eb == '0)
                w_mul = c_nan;
            else
                w_mul = {w_sa ^ w_sb, c_exp_ones, {MAN_W{1'b0}}};
        end else if (w_ea == '0 || w_eb == '0) begin
            w_mul = '0;
        end else if (w_mexp[EXP_W+1] || w_mexp == '0) begin
            w_mul = '0;
        end else if (w_mexp[EXP_W:0] >= {1'b0, c_exp_ones}) begin
            w_mul = {w_sa ^ w_sb, c_exp_ones, {MAN_W{1'b0}}};
        end else begin
            w_mul = {w_sa ^ w_sb, w_mexp[EXP_W-1:0], w_mman};
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulator adder (x = accumulator, y = product)
    // ------------------------------------------------------------------
    logic             w_xs, w_ys;
    logic [EXP_W-1:0] w_xe, w_ye;
    logic [MAN_W-1:0] w_xm, w_ym;
    logic             w_x_nan, w_y_nan, w_x_inf, w_y_inf;
    logic             w_swap, w_bs;
    logic [EXP_W-1:0] w_be, w_se;
    logic [MAN_W:0]   w_bm, w_sm;
    logic [MAN_W+1:0] w_add;
    logic [MAN_W:0]   w_diff;
    logic [MAN_W:0]   w_norm;
    logic [c_lzw-1:0] w_lz;
    logic [c_xw-1:0]  w_re;
    logic [c_w-1:0]   w_sum;
    logic [c_w-1:0]   w_acc_next;
    logic             w_unused;

    assign {w_xs, w_xe, w_xm} = r_acc;
    assign {w_ys, w_ye, w_ym} = r_prod;
    assign w_x_inf = (&w_xe) && (w_xm == '0);
    assign w_y_inf = (&w_ye) && (w_ym == '0);
    assign w_x_nan = (&w_xe) && (w_xm != '0);
    assign w_y_nan = (&w_ye) && (w_ym != '0);

    always_comb begin
        w_swap = {w_ye, w_ym} > {w_xe, w_xm};
        w_bs   = w_swap ? w_ys : w_xs;
        w_be   = w_swap ? w_ye : w_xe;
        w_se   = w_swap ? w_xe : w_ye;
        w_bm   = {1'b1, (w_swap ? w_ym : w_xm)};
        w_sm   = {1'b1, (w_swap ? w_xm : w_ym)} >> (w_be - w_se);
        w_add  = {1'b0, w_bm} + {1'b0, w_sm};
        w_diff = w_bm - w_sm;
        w_lz   = '0;
        for (int i = 0; i <= MAN_W; i++) begin
            if (w_diff[i])
                w_lz = c_lzw'(MAN_W - i);
        end
        w_norm = w_diff << w_lz;
        w_re   = '0;
        w_sum  = '0;

        if (w_x_nan || w_y_nan || (w_x_inf && w_y_inf && (w_xs != w_ys))) begin
            w_sum = c_nan;
        end else if (w_x_inf) begin
            w_sum = r_acc;
        end else if (w_y_inf) begin
            w_sum = r_prod;
        end else if (w_xe == '0) begin
            w_sum = (w_ye == '0) ? '0 : r_prod;
        end else if (w_ye == '0) begin
            w_sum = r_acc;
        end else if (w_xs == w_ys) begin
            w_re = c_xw'(w_be) + c_xw'(w_add[MAN_W+1]);
            if (w_re >= c_xw'(c_exp_ones))
                w_sum = {w_bs, c_exp_ones, {MAN_W{1'b0}}};
            else if (w_add[MAN_W+1])
                w_sum = {w_bs, w_re[EXP_W-1:0], w_add[MAN_W:1]};
            else
                w_sum = {w_bs, w_re[EXP_W-1:0], w_add[MAN_W-1:0]};
        end else begin
            // exact cancellation and underflow both land on +0
            w_re = c_xw'(w_be) - c_xw'(w_lz);
            if (w_diff == '0 || c_xw'(w_lz) >= c_xw'(w_be))
                w_sum = '0;
            else
                w_sum = {w_bs, w_re[EXP_W-1:0], w_norm[MAN_W-1:0]};
        end
    end

    assign w_acc_next = r_p_valid ? w_sum : r_acc;
    assign w_unused   = ^{w_prod_man[MAN_W-1:0], w_norm[MAN_W]};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_a_out     <= a_in;
            r_b_out     <= b_in;
            r_out_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_valid <= 1'b0;
            r_p_drain <= 1'b0;
            r_prod    <= '0;
        end else if (clr) begin
            r_p_valid <= 1'b0;
            r_p_drain <= 1'b0;
        end else begin
            r_p_valid <= in_valid;
            r_p_drain <= drain;
            if (in_valid)
                r_prod <= w_mul;
        end
    end

    // A drain captures the sum including a product arriving alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_acc_out   <= '0;
            r_acc_valid <= 1'b0;
        end else if (clr) begin
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= r_p_drain;
            if (r_p_drain) begin
                r_acc     <= '0;
                r_acc_out <= w_acc_next;
            end else begin
                r_acc     <= w_acc_next;
            end
        end
    end

    assign a_out     = r_a_out;
    assign b_out     = r_b_out;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc_out;
    assign acc_valid = r_acc_valid;

endmodule
`default_nettype wire

// File: tb/tb_systolic_fp_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_fp_pe
// Purpose  : Scoreboard bench for systolic_fp_pe with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_fp_pe;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        drain = 1'b0;
    logic [31:0] a_out, b_out, acc_out;
    logic        out_valid, acc_valid;

    int   total = 0;
    int   bad = 0;
    int   cyc_cnt = 0;
    exp_t pt_q[$];
    exp_t acc_q[$];

    localparam logic [31:0] c_56  = 32'h42600000;
    localparam logic [31:0] c_10  = 32'h41200000;
    localparam logic [31:0] c_one = 32'h3F800000;

    systolic_fp_pe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .drain     (drain),
        .a_out     (a_out),
        .b_out     (b_out),
        .out_valid (out_valid),
        .acc_out   (acc_out),
        .acc_valid (acc_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    // One clock of stimulus; expectations are queued before the edge
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic dr, input logic cl, input logic expect_acc,
                        input logic [31:0] exp_acc);
        in_valid = iv;
        a_in     = a;
        b_in     = b;
        drain    = dr;
        clr      = cl;
        if (iv)
            pt_q.push_back('{a, b, cyc_cnt + 1});
        if (dr && !cl && expect_acc)
            acc_q.push_back('{exp_acc, 32'h0, cyc_cnt + 2});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain    = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_a_out"}, a_out, 32'h0);
        check({name, "_b_out"}, b_out, 32'h0);
        check({name, "_acc_out"}, acc_out, 32'h0);
        check({name, "_valids"}, {30'h0, out_valid, acc_valid}, 32'h0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (pt_q.size() == 0) begin
                    check("passthru_unexpected", {31'h0, out_valid}, 32'h0);
                end else begin
                    e = pt_q.pop_front();
                    check("passthru_a", a_out, e.d0);
                    check("passthru_b", b_out, e.d1);
                    check("passthru_latency", cyc_cnt, e.cyc);
                end
            end
            if (acc_valid) begin
                if (acc_q.size() == 0) begin
                    check("acc_valid_unexpected", {31'h0, acc_valid}, 32'h0);
                end else begin
                    e = acc_q.pop_front();
                    check("acc_out", acc_out, e.d0);
                    check("acc_latency", cyc_cnt, e.cyc);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Single product drained in the same cycle
        step(1'b1, c_56, c_10, 1'b1, 1'b0, 1'b1, 32'h440C0000);
        idle(2);

        // Two products, then restart at zero
        step(1'b1, c_56, c_10, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, c_56, c_10, 1'b1, 1'b0, 1'b1, 32'h448C0000);
        step(1'b1, c_56, c_10, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h440C0000);
        idle(2);

        // 9 + -9 cancels to +0
        step(1'b1, 32'h40400000, 32'h40400000, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h40400000, 32'hC0400000, 1'b1, 1'b0, 1'b1, 32'h00000000);
        idle(2);

        // Special values with back-to-back drains
        step(1'b1, 32'h7F000000, 32'h7F000000, 1'b1, 1'b0, 1'b1, 32'h7F800000);
        step(1'b1, 32'h00800000, 32'h00800000, 1'b1, 1'b0, 1'b1, 32'h00000000);
        step(1'b1, 32'h7F800000, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h7FC00000);
        step(1'b1, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, c_one, c_one, 1'b1, 1'b0, 1'b1, 32'h7FC00000);
        idle(3);

        // clr discards the accumulated 560 and the same-cycle pair
        step(1'b1, c_56, c_10, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1);
        step(1'b1, c_56, c_10, 1'b0, 1'b1, 1'b0, 32'h0);
        check("acc_out_hold_after_clr", acc_out, 32'h7FC00000);
        step(1'b1, c_one, c_one, 1'b1, 1'b0, 1'b1, 32'h3F800000);
        idle(3);

        // Reset lands while a drain is in flight: no pulse may follow
        step(1'b1, c_56, c_10, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("in_reset");
        @(negedge clk);
        check_outputs_zero("in_reset_late");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        step(1'b1, c_56, c_10, 1'b1, 1'b0, 1'b1, 32'h440C0000);
        idle(4);

        wait_cnt = 0;
        while ((pt_q.size() != 0 || acc_q.size() != 0) && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("pending_passthru", pt_q.size(), 32'h0);
        check("pending_acc", acc_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
